// File: rtl/kws_pkg.sv
// Shared defaults and FSM state type for the keyword-spotting front end.
package kws_pkg;

  localparam int unsigned DEF_DATA_W    = 12;
  localparam int unsigned DEF_FRAME_LEN = 128;
  localparam int unsigned DEF_HOP       = 64;
  localparam int unsigned DEF_BUF_DEPTH = 256;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStream,
    StDone
  } seq_state_e;

endpackage

// File: rtl/frame_buffer.sv
// Simple dual-port sample RAM: one write port, one registered read port (1-cycle latency).
module frame_buffer #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; data holds while rd_en is low so a stalled consumer sees a stable value.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Overlapping-frame sequencer: buffers incoming samples in a circular RAM and streams
// FRAME_LEN-sample frames every HOP samples over a valid/ready handshake.
module frame_sequencer
  import kws_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned HOP       = DEF_HOP,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sample,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [15:0]       frame_count,
  output logic              overrun
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] FillTrig   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FillReload = CNT_W'(FRAME_LEN - HOP);
  localparam logic [CNT_W-1:0] IdxLast    = CNT_W'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0] PtrOne     = PTR_W'(1);
  localparam logic [PTR_W-1:0] PtrFrame   = PTR_W'(FRAME_LEN);

  seq_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              pend_q, pend_d;
  logic [PTR_W-1:0]  pend_base_q, pend_base_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              trig;
  logic [PTR_W-1:0]  trig_base;
  logic              pend_live;
  logic              rd_en;
  logic [PTR_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign accept    = enable & in_valid;
  // Oldest sample of the frame that ends with the sample being written this cycle.
  assign trig_base = wr_ptr_q + PtrOne - PtrFrame;
  assign pend_live = pend_q & enable;

  frame_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (PTR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (in_sample),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Fill counter: first trigger after FRAME_LEN samples, then every HOP samples.
  always_comb begin
    trig   = 1'b0;
    fill_d = fill_q;
    if (!enable) begin
      fill_d = '0;
    end else if (in_valid) begin
      if (fill_q == FillTrig) begin
        trig   = 1'b1;
        fill_d = FillReload;
      end else begin
        fill_d = fill_q + CNT_W'(1);
      end
    end
  end

  // Next-state, read scheduling, pending-trigger slot and overrun.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    idx_d         = idx_q;
    rd_en         = 1'b0;
    rd_addr       = rd_ptr_q;
    frame_count_d = frame_count_q;
    pend_d        = pend_q;
    pend_base_d   = pend_base_q;
    overrun_d     = overrun_q;

    if (trig && pend_q) begin
      overrun_d = 1'b1;
    end else if (trig && (state_q == StLoad || state_q == StStream)) begin
      pend_d      = 1'b1;
      pend_base_d = trig_base;
    end
    // The DONE cycle always consumes the slot (either starting it or finding it empty).
    if (state_q == StDone || !enable) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (trig) begin
          rd_ptr_d = trig_base;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        rd_en   = 1'b1;
        rd_addr = rd_ptr_q;
        idx_d   = '0;
        state_d = StStream;
      end
      StStream: begin
        if (out_ready) begin
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else begin
            rd_en    = 1'b1;
            rd_addr  = rd_ptr_q + PtrOne;
            rd_ptr_d = rd_ptr_q + PtrOne;
            idx_d    = idx_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        frame_count_d = frame_count_q + 16'd1;
        // Prefetch the next frame's first sample here so streaming resumes without a LOAD.
        if (pend_live || trig) begin
          rd_en    = 1'b1;
          rd_addr  = pend_live ? pend_base_q : trig_base;
          rd_ptr_d = pend_live ? pend_base_q : trig_base;
          idx_d    = '0;
          state_d  = StStream;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      pend_q        <= 1'b0;
      pend_base_q   <= '0;
      rd_ptr_q      <= '0;
      idx_q         <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      pend_q        <= pend_d;
      pend_base_q   <= pend_base_d;
      rd_ptr_q      <= rd_ptr_d;
      idx_q         <= idx_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    out_valid   = (state_q == StStream);
    out_sample  = out_valid ? rd_data : '0;
    out_first   = out_valid && (idx_q == '0);
    out_last    = out_valid && (idx_q == IdxLast);
    frame_count = frame_count_q;
    overrun     = overrun_q;
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a frame-level model.
module tb_frame_sequencer;

  localparam int DW  = 12;
  localparam int FL  = 128;
  localparam int HP  = 64;
  localparam int BD  = 256;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [DW-1:0] in_sample;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] out_sample;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic [15:0]   frame_count;
  logic          overrun;

  frame_sequencer #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .HOP       (HP),
    .BUF_DEPTH (BD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .out_first   (out_first),
    .out_last    (out_last),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: every accepted sample in order, and the start index (into hist)
  // of each frame that has been triggered and not yet retired.
  int  hist[$];
  int  q[$];
  int  seen[$];
  int  fill;
  int  idx;
  int  cyc;
  int  valid_from;
  int  m_fcount;
  int  m_ovr;
  int  vcount;
  bit  done_ph;
  bit  live = 1'b0;
  bit  exp_v;
  bit  hs;

  // Compare DUT to the model, then advance the model by the inputs about to be sampled.
  always @(negedge clk) begin
    exp_v = live && (q.size() > 0) && (cyc >= valid_from) && !done_ph;
    if (live) begin
      chk("out_valid", int'(out_valid), int'(exp_v));
      if (exp_v) begin
        chk("out_sample", int'(out_sample), hist[q[0] + idx]);
        chk("out_first", int'(out_first), int'(idx == 0));
        chk("out_last", int'(out_last), int'(idx == FL - 1));
      end
      chk("frame_count", int'(frame_count), m_fcount);
      chk("overrun", int'(overrun), m_ovr);
      if (out_valid) vcount++;
    end
    hs = exp_v && out_ready;
    if (hs) seen.push_back(int'(out_sample));
    if (rst) begin
      live = 1'b1;
      hist.delete();
      q.delete();
      fill = 0;
      idx = 0;
      done_ph = 1'b0;
      m_fcount = 0;
      m_ovr = 0;
      vcount = 0;
      valid_from = 0;
    end else if (live) begin
      if (enable && in_valid) begin
        hist.push_back(int'(in_sample));
        fill++;
        if (fill >= FL && (fill - FL) % HP == 0) begin
          if (q.size() >= 2) begin
            m_ovr = 1;
          end else begin
            if (q.size() == 0) valid_from = cyc + 2;
            q.push_back(hist.size() - FL);
          end
        end
      end
      if (!enable) begin
        fill = 0;
        if (q.size() == 2) void'(q.pop_back());
      end
      if (done_ph) begin
        void'(q.pop_front());
        m_fcount = (m_fcount + 1) % 65536;
        done_ph = 1'b0;
        if (q.size() > 0) valid_from = cyc + 1;
      end else if (hs) begin
        idx++;
        if (idx == FL) begin
          idx = 0;
          done_ph = 1'b1;
        end
      end
    end
    cyc++;
  end

  // 0: ready high, 1: toggle, 2: held low, 3: random
  int ready_mode = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic push(input int val, input int gap);
    in_sample = DW'(val);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    for (int i = 1; i < gap; i++) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(n >= 4000), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_overrun", int'(overrun), 0);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    enable = 1'b0;
    in_valid = 1'b0;
    in_sample = '0;
    out_ready = 1'b1;
    do_reset();
    enable = 1'b1;

    // First frame: values 0..127, one sample every 4 cycles.
    for (int i = 0; i < FL - 1; i++) push(i, 4);
    push(FL - 1, 1);
    @(negedge clk);
    chk("lat_load_cycle", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_two_cycles", int'(out_valid), 1);
    drain();
    chk("f1_len", seen.size(), 128);
    chk("f1_first", seen[0], 0);
    chk("f1_last", seen[127], 127);
    chk("f1_count", int'(frame_count), 1);

    // Continue through the pointer wrap.
    for (int i = FL; i < 320; i++) push(i, 4);
    drain();
    chk("f4_len", seen.size(), 512);
    chk("f2_first", seen[128], 64);
    chk("f2_last", seen[255], 191);
    chk("f3_first", seen[256], 128);
    chk("f4_first", seen[384], 192);
    chk("f4_last", seen[511], 319);
    chk("f4_count", int'(frame_count), 4);

    // Alternating ready.
    ready_mode = 1;
    for (int i = 320; i < 448; i++) push(i, 4);
    drain();
    chk("toggle_count", int'(frame_count), 6);
    chk("toggle_overrun", int'(overrun), 0);

    // Ready held low across three triggers: one waits, one pends, one drops.
    ready_mode = 2;
    out_ready = 1'b0;
    for (int i = 448; i < 640; i++) push(i, 4);
    chk("stall_overrun", int'(overrun), 1);
    chk("stall_count", int'(frame_count), 6);
    ready_mode = 0;
    drain();
    chk("overrun_sticky", int'(overrun), 1);
    chk("stall_drain_count", int'(frame_count), 8);

    // Enable drop clears the fill count.
    do_reset();
    for (int i = 0; i < 100; i++) push(i, 2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push(1000 + i, 2);
    enable = 1'b1;
    for (int i = 0; i < FL - 1; i++) push(2000 + i, 2);
    chk("reenable_no_frame", int'(frame_count), 0);
    chk("reenable_no_valid", vcount, 0);
    push(2000 + FL - 1, 1);
    base = seen.size();
    n = 0;
    while (seen.size() < base + 50 && n < 1000) begin
      tick();
      n++;
    end
    chk("mid_wait_timeout", int'(n >= 1000), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_count", int'(frame_count), 0);

    // Randomized traffic.
    tick();
    enable = 1'b1;
    ready_mode = 3;
    for (int c = 0; c < 4000; c++) begin
      enable    = ($urandom_range(0, 999) != 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      in_sample = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    enable = 1'b1;
    ready_mode = 0;
    drain();
    chk("rand_count", int'(frame_count), m_fcount);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
